// File: rtl/router_fsm.sv
// ============================================================================
// router_fsm : 1x3 router control FSM (header decode, load, full stall, parity)
// Optional macro ROUTER_FSM_TIMEOUT_EN adds a WAIT_TILL_EMPTY timeout/drop_pkt.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module router_fsm #(
    parameter int WAIT_LIMIT = 64,
    parameter int CNT_W      = 7
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       write_enb_reg,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_in_reg,
    output logic       busy
`ifdef ROUTER_FSM_TIMEOUT_EN
    ,
    output logic       drop_pkt
`endif
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    if (2**CNT_W <= WAIT_LIMIT) begin : g_cnt_w_check
        $error("router_fsm: CNT_W too narrow for WAIT_LIMIT");
    end

    state_t     state, state_nxt;
    logic [1:0] addr_q;
    logic       sel_empty, sel_soft, hdr_empty, timeout;

    always_comb begin
        sel_empty = 1'b0;
        sel_soft  = 1'b0;
        hdr_empty = 1'b0;
        case (addr_q)
            2'd0:    begin sel_empty = fifo_empty_0; sel_soft = soft_reset_0; end
            2'd1:    begin sel_empty = fifo_empty_1; sel_soft = soft_reset_1; end
            2'd2:    begin sel_empty = fifo_empty_2; sel_soft = soft_reset_2; end
            default: ;
        endcase
        case (data_in)
            2'd0:    hdr_empty = fifo_empty_0;
            2'd1:    hdr_empty = fifo_empty_1;
            2'd2:    hdr_empty = fifo_empty_2;
            default: ;
        endcase
    end

`ifdef ROUTER_FSM_TIMEOUT_EN
    logic [CNT_W-1:0] wait_cnt;

    // Counter sits at zero outside WAIT_TILL_EMPTY, so it is clear on entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            wait_cnt <= '0;
        else if (state != WAIT_TILL_EMPTY)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + 1'b1;
    end

    assign timeout  = (wait_cnt == CNT_W'(WAIT_LIMIT - 1));
    assign drop_pkt = (state == WAIT_TILL_EMPTY) && !sel_empty && timeout;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= DECODE_ADDRESS;
            addr_q <= 2'd0;
        end else begin
            state <= state_nxt;
            if (state == DECODE_ADDRESS && pkt_valid && data_in != 2'd3)
                addr_q <= data_in;
        end
    end

    always_comb begin
        state_nxt = DECODE_ADDRESS;
        if (sel_soft && state != DECODE_ADDRESS) begin
            state_nxt = DECODE_ADDRESS;
        end else begin
            case (state)
                DECODE_ADDRESS: begin
                    state_nxt = DECODE_ADDRESS;
                    if (pkt_valid && data_in != 2'd3)
                        state_nxt = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
                LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full)       state_nxt = FIFO_FULL_STATE;
                    else if (!pkt_valid) state_nxt = LOAD_PARITY;
                    else                 state_nxt = LOAD_DATA;
                end
                FIFO_FULL_STATE: state_nxt = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
                LOAD_AFTER_FULL: begin
                    if (parity_done)        state_nxt = DECODE_ADDRESS;
                    else if (low_pkt_valid) state_nxt = LOAD_PARITY;
                    else                    state_nxt = LOAD_DATA;
                end
                LOAD_PARITY:        state_nxt = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: state_nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                WAIT_TILL_EMPTY: begin
                    if (sel_empty)    state_nxt = LOAD_FIRST_DATA;
                    else if (timeout) state_nxt = DECODE_ADDRESS;
                    else              state_nxt = WAIT_TILL_EMPTY;
                end
                default: state_nxt = DECODE_ADDRESS;
            endcase
        end
    end

    always_comb begin
        detect_add    = (state == DECODE_ADDRESS);
        lfd_state     = (state == LOAD_FIRST_DATA);
        ld_state      = (state == LOAD_DATA);
        full_state    = (state == FIFO_FULL_STATE);
        laf_state     = (state == LOAD_AFTER_FULL);
        rst_in_reg    = (state == CHECK_PARITY_ERROR);
        write_enb_reg = (state == LOAD_DATA) || (state == LOAD_AFTER_FULL) ||
                        (state == LOAD_PARITY);
        busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));
    end

endmodule

`default_nettype wire

// File: tb/tb_router_fsm.sv
// Directed-vector bench for router_fsm; expected states queued, monitor compares.
`default_nettype none

module tb_router_fsm;

    localparam logic [2:0] DEC = 3'd0, LFD = 3'd1, LD = 3'd2, FUL = 3'd3,
                           LAF = 3'd4, LP  = 3'd5, CPE = 3'd6, WT = 3'd7;

    logic       clk = 1'b0;
    logic       resetn;
    logic       pkt_valid, fifo_full, parity_done, low_pkt_valid;
    logic [1:0] data_in;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       write_enb_reg, detect_add, lfd_state, ld_state;
    logic       laf_state, full_state, rst_in_reg, busy;
`ifdef ROUTER_FSM_TIMEOUT_EN
    logic       drop_pkt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [2:0] st;
        logic       drop;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

`ifdef ROUTER_FSM_TIMEOUT_EN
    router_fsm #(.WAIT_LIMIT(8), .CNT_W(4)) dut (
`else
    router_fsm dut (
`endif
        .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full),
        .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
        .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .write_enb_reg(write_enb_reg), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_in_reg(rst_in_reg), .busy(busy)
`ifdef ROUTER_FSM_TIMEOUT_EN
        , .drop_pkt(drop_pkt)
`endif
    );

    // Expected {write_enb, detect, lfd, ld, laf, full, rst_in, busy} per state.
    function automatic logic [7:0] exp_vec(input logic [2:0] s);
        case (s)
            DEC:     return 8'b0100_0000;
            LFD:     return 8'b0010_0001;
            LD:      return 8'b1001_0000;
            FUL:     return 8'b0000_0101;
            LAF:     return 8'b1000_1001;
            LP:      return 8'b1000_0001;
            CPE:     return 8'b0000_0011;
            default: return 8'b0000_0001;
        endcase
    endfunction

    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {write_enb_reg, detect_add, lfd_state, ld_state,
                       laf_state, full_state, rst_in_reg, busy};
                vectors++;
                if (act !== exp_vec(e.st)) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t exp_state=%0d got %b want %b",
                             $time, e.st, act, exp_vec(e.st));
                end
`ifdef ROUTER_FSM_TIMEOUT_EN
                vectors++;
                if (drop_pkt !== e.drop) begin
                    miscompares++;
                    $display("FAIL drop_pkt t=%0t got %b want %b", $time, drop_pkt, e.drop);
                end
`endif
            end
        end
    end

    task automatic step(input logic [2:0] st, input logic drp);
        exp_t e;
        e.st   = st;
        e.drop = drp;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic set_emp(input logic [2:0] m);
        {fifo_empty_2, fifo_empty_1, fifo_empty_0} = m;
    endtask

    task automatic set_soft(input logic [2:0] m);
        {soft_reset_2, soft_reset_1, soft_reset_0} = m;
    endtask

    initial begin
        resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        parity_done = 1'b0; low_pkt_valid = 1'b0;
        set_emp(3'b111); set_soft(3'b000);
        step(DEC, 0); step(DEC, 0);
        resetn = 1'b1;
        step(DEC, 0); step(DEC, 0);

        // addr 2 packet, 5 payload bytes then parity
        pkt_valid = 1'b1; data_in = 2'd2; step(LFD, 0);
        data_in = 2'd1;
        repeat (5) step(LD, 0);
        pkt_valid = 1'b0; step(LP, 0); step(CPE, 0); step(DEC, 0);

        // addr 1 waits for empty, then full stall mid-payload
        pkt_valid = 1'b1; data_in = 2'd1; set_emp(3'b101); step(WT, 0);
        data_in = 2'd0;
        repeat (3) step(WT, 0);
        set_emp(3'b111); step(LFD, 0);
        step(LD, 0); step(LD, 0);
        fifo_full = 1'b1;
        repeat (3) step(FUL, 0);
        fifo_full = 1'b0; step(LAF, 0); step(LD, 0);
        pkt_valid = 1'b0; step(LP, 0); step(CPE, 0); step(DEC, 0);

        // addr 0: full with pkt_valid falling, LAF exits, parity check into full
        pkt_valid = 1'b1; data_in = 2'd0; step(LFD, 0); step(LD, 0);
        pkt_valid = 1'b0; fifo_full = 1'b1; step(FUL, 0);
        fifo_full = 1'b0; step(LAF, 0);
        low_pkt_valid = 1'b1; step(LP, 0);
        low_pkt_valid = 1'b0; step(CPE, 0);
        fifo_full = 1'b1; step(FUL, 0);
        fifo_full = 1'b0; step(LAF, 0);
        parity_done = 1'b1; step(DEC, 0);
        parity_done = 1'b0;

        // soft resets: wrong FIFO ignored, selected FIFO aborts; invalid header
        pkt_valid = 1'b1; data_in = 2'd2; step(LFD, 0);
        data_in = 2'd0; step(LD, 0);
        set_soft(3'b001); step(LD, 0);
        set_soft(3'b100); step(DEC, 0);
        set_soft(3'b000); data_in = 2'd3; step(DEC, 0); step(DEC, 0);
        pkt_valid = 1'b0; data_in = 2'd0; step(DEC, 0);

        // soft reset leaves WAIT_TILL_EMPTY
        pkt_valid = 1'b1; data_in = 2'd1; set_emp(3'b101); step(WT, 0);
        pkt_valid = 1'b0; set_soft(3'b010); step(DEC, 0);
        set_soft(3'b000); set_emp(3'b111); step(DEC, 0);

        // asynchronous reset mid-packet
        pkt_valid = 1'b1; data_in = 2'd2; step(LFD, 0); step(LD, 0);
        resetn = 1'b0;
        #1;
        vectors++;
        if (detect_add !== 1'b1 || ld_state !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset got detect=%b ld=%b want detect=1 ld=0",
                     detect_add, ld_state);
        end
        pkt_valid = 1'b0; step(DEC, 0);
        resetn = 1'b1; step(DEC, 0);

`ifdef ROUTER_FSM_TIMEOUT_EN
        // timeout with WAIT_LIMIT=8: drop on the 8th WAIT cycle
        pkt_valid = 1'b1; data_in = 2'd0; set_emp(3'b110); step(WT, 0);
        pkt_valid = 1'b0;
        repeat (6) step(WT, 0);
        step(WT, 1);
        step(DEC, 0);
        set_emp(3'b111); step(DEC, 0);
`endif

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
